// File: rtl/cmos_capture_rgb565.sv
// DVP camera capture: packs sensor byte pairs into RGB565 words for the SDRAM write FIFO.
// Define CMOS_COLORBAR_EN to replace the sensor pixels with an 8-bar test pattern.
module cmos_capture_rgb565 #(
    parameter int FRAME_SKIP = 10,
    parameter int IMG_HDISP  = 480,
    parameter int IMG_VDISP  = 272
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sdram_init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        sys_we,
    output logic [15:0] sys_data_in,
    output logic        frame_valid,
    output logic [10:0] pixel_cnt,
    output logic [10:0] line_cnt,
    output logic        frame_err
);

    localparam logic [7:0]  SKIP_LAST = 8'(FRAME_SKIP - 1);
    localparam logic [10:0] HDISP     = 11'(IMG_HDISP);
    localparam logic [10:0] VDISP     = 11'(IMG_VDISP);
    localparam logic [10:0] CNT_MAX   = 11'h7FF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SKIP    = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  skip_cnt;

    logic        vs_d;
    logic        vs_d2;
    logic        hs_d;
    logic        hs_d2;
    logic [7:0]  dat_d;

    logic        vs_rise;
    logic        hs_fall;
    logic        line_active;
    logic        capturing;

    logic        byte_flag;
    logic [7:0]  hi_byte;
    logic        frame_bad;
    logic [15:0] pixel_word;

    function automatic logic [10:0] sat_inc(input logic [10:0] cnt);
        return (cnt == CNT_MAX) ? cnt : cnt + 11'd1;
    endfunction

`ifdef CMOS_COLORBAR_EN
    localparam logic [10:0] BAR_W = 11'(IMG_HDISP / 8);

    function automatic logic [15:0] bar_color(input logic [10:0] px);
        logic [10:0] idx;
        idx = px / BAR_W;
        case (idx)
            11'd0:   bar_color = 16'hFFFF;
            11'd1:   bar_color = 16'hFFE0;
            11'd2:   bar_color = 16'h07FF;
            11'd3:   bar_color = 16'h07E0;
            11'd4:   bar_color = 16'hF81F;
            11'd5:   bar_color = 16'hF800;
            11'd6:   bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    assign pixel_word = bar_color(pixel_cnt);
`else
    assign pixel_word = {hi_byte, dat_d};
`endif

    // Input stage: one register on the sensor bus, a second on the syncs for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_d  <= 1'b0;
            vs_d2 <= 1'b0;
            hs_d  <= 1'b0;
            hs_d2 <= 1'b0;
            dat_d <= 8'h00;
        end else begin
            vs_d  <= cmos_vsync;
            vs_d2 <= vs_d;
            hs_d  <= cmos_href;
            hs_d2 <= hs_d;
            dat_d <= cmos_data;
        end
    end

    assign vs_rise     = vs_d & ~vs_d2;
    assign hs_fall     = hs_d2 & ~hs_d;
    assign line_active = hs_d & ~vs_d;
    assign capturing   = (state == CAPTURE);
    assign frame_valid = capturing;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (sdram_init_done) state_next = SKIP;
            SKIP:    if (vs_rise && (skip_cnt == SKIP_LAST)) state_next = CAPTURE;
            CAPTURE: state_next = CAPTURE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_cnt <= 8'd0;
        end else if ((state == SKIP) && vs_rise) begin
            skip_cnt <= skip_cnt + 8'd1;
        end
    end

    // Packing stage: operates on the registered bus, one pixel per two href bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sys_we      <= 1'b0;
            sys_data_in <= 16'h0000;
            pixel_cnt   <= 11'd0;
            line_cnt    <= 11'd0;
            frame_err   <= 1'b0;
            byte_flag   <= 1'b0;
            hi_byte     <= 8'h00;
            frame_bad   <= 1'b0;
        end else begin
            sys_we    <= 1'b0;
            frame_err <= 1'b0;
            if (capturing) begin
                if (vs_rise) begin
                    frame_err <= frame_bad | (line_cnt != VDISP);
                    // href already high on this cycle belongs to the next frame's error state
                    frame_bad <= hs_d;
                    pixel_cnt <= 11'd0;
                    line_cnt  <= 11'd0;
                    byte_flag <= 1'b0;
                end else begin
                    if (hs_d && vs_d) begin
                        frame_bad <= 1'b1;
                    end
                    if (line_active) begin
                        byte_flag <= ~byte_flag;
                        if (!byte_flag) begin
                            hi_byte <= dat_d;
                        end else begin
                            if ((pixel_cnt < HDISP) && (line_cnt < VDISP)) begin
                                sys_we      <= 1'b1;
                                sys_data_in <= pixel_word;
                            end
                            pixel_cnt <= sat_inc(pixel_cnt);
                        end
                    end else begin
                        byte_flag <= 1'b0;
                        if (hs_fall) begin
                            // A set flag here means a dangling high byte that is dropped
                            if (byte_flag) begin
                                frame_bad <= 1'b1;
                            end
                            if (pixel_cnt != 11'd0) begin
                                line_cnt <= sat_inc(line_cnt);
                                if (pixel_cnt != HDISP) begin
                                    frame_bad <= 1'b1;
                                end
                            end
                            pixel_cnt <= 11'd0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/cmos_capture_rgb565.md
Name: cmos_capture_rgb565

Overview:
Camera-side writer for the SDRAM frame buffer. Samples an 8-bit DVP sensor bus (vsync/href/data) in the pixel-clock domain and packs byte pairs into RGB565 words. Drives the write FIFO interface (sys_we/sys_data_in) and the frame_valid level consumed by the bank switcher. Gates capture until SDRAM init completes and the sensor has settled; clips every frame to the panel geometry so the write address never overruns a bank.

Parameters:
FRAME_SKIP, 10, number of complete sensor frames discarded after sdram_init_done before capture starts (1..255)
IMG_HDISP, 480, pixels per line written to SDRAM
IMG_VDISP, 272, lines per frame written to SDRAM

Ports:
clk  input  1  sensor pixel clock (PCLK); sole clock of the block
rst_n  input  1  asynchronous active-low reset
sdram_init_done  input  1  level; capture is held off while low
cmos_vsync  input  1  sensor vsync, active high during vertical blanking
cmos_href  input  1  sensor line-valid, active high
cmos_data  input  8  sensor byte bus; first byte = RGB565[15:8], second = [7:0]
sys_we  output  1  one-cycle write strobe per packed pixel
sys_data_in  output  16  packed RGB565 pixel, valid when sys_we=1
frame_valid  output  1  level; high once capture is running
pixel_cnt  output  11  packed pixels in the current line
line_cnt  output  11  completed lines in the current frame
frame_err  output  1  one-cycle pulse at frame end if geometry mismatched

Behaviour:
- Reset: all outputs 0; state IDLE; skip counter, byte flag, counters cleared. Reset mid-frame aborts silently; no partial word is emitted.
- Input stage: cmos_vsync/href/data registered once (vs_d, hs_d, dat_d); vs_d delayed again for edges. vs_rise = vs_d & ~vs_d2 marks end of frame / frame boundary.
- FSM:
  - IDLE: wait for sdram_init_done=1, then SKIP.
  - SKIP: count vs_rise; after FRAME_SKIP rises go to CAPTURE. frame_valid rises in the same cycle as the transition.
  - CAPTURE: terminal; frame_valid stays 1. sdram_init_done falling in CAPTURE has no effect.
- Packing (CAPTURE only): byte_flag toggles on every cycle with hs_d=1; cleared when hs_d=0.
  - Flag 0: latch dat_d as high byte.
  - Flag 1: register sys_data_in={hi,dat_d} and pulse sys_we for one cycle.
  - Latency: sys_we is asserted 2 clk after the second byte is present on cmos_data.
- Counters:
  - pixel_cnt increments on each packed pixel; cleared on hs_d falling edge.
  - line_cnt increments on hs_d falling edge if pixel_cnt>0.
  - Both cleared on vs_rise.
- Clipping: a packed pixel with pixel_cnt>=IMG_HDISP or line_cnt>=IMG_VDISP is not written (sys_we stays 0). Counters saturate at 2047.
- Odd byte count at href fall: the dangling high byte is dropped and the line is flagged bad.
- frame_err pulses 1 cycle coincident with vs_rise (CAPTURE only) if any of these held during the frame:
  - line_cnt != IMG_VDISP
  - any line had pixel_cnt != IMG_HDISP
  - a line had an odd byte count
- href asserted while vsync high: bytes ignored, no write, error flagged.
- Output order is strictly sensor raster order; no buffering beyond one pixel.

Optional Feature:
Macro CMOS_COLORBAR_EN. When defined, sys_data_in is replaced by an 8-bar test pattern selected by pixel_cnt[IMG_HDISP/8 slices]: white, yellow, cyan, green, magenta, red, blue, black (16'hFFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000). Sensor timing, sys_we, counters and errors are unchanged. When undefined, the sensor bytes are passed through.

Test Plan:
- Reset/hold-off: sdram_init_done=0 with 3 valid frames -> sys_we never 1, frame_valid=0; release rst_n mid-line -> all outputs 0 within 1 clk.
- Skip: FRAME_SKIP=2, init_done=1, 3 frames of 480x272 -> no writes in frames 1-2; frame_valid rises on 2nd vs_rise; frame 3 gives exactly 130560 sys_we pulses, frame_err=0.
- Packing/latency: bytes 0xF8,0x1F on consecutive href cycles -> sys_we=1 with sys_data_in=16'hF81F exactly 2 clk after byte 0x1F.
- Clipping: frame of 500x280 -> 480 writes per line, 272 lines written, frame_err pulse at vs_rise.
- Odd byte: line with 961 bytes -> 480 writes, last byte dropped, frame_err=1 at frame end; next clean frame -> frame_err=0.
- CMOS_COLORBAR_EN defined: pixel 0 -> 16'hFFFF, pixel 60 -> 16'hFFE0, pixel 479 -> 16'h0000 regardless of cmos_data.
